// File: rtl/bht_predictor_if.sv
// rtl/bht_predictor_if.sv - fetch/EX signal bundle for the branch history table
// BrCount/MissCount exist only when BHT_STATS_EN is defined.
interface bht_predictor_if;
  logic [31:0] PCF;
  logic        StallD;
  logic        FlushD;
  logic        StallE;
  logic        FlushE;
  logic        BranchE;
  logic        BrTakenE;
  logic [31:0] BranchTargetE;
  logic        BHThit;
  logic [31:0] PrePC;
  logic [1:0]  PredictMiss;
  logic [31:0] Expc;
`ifdef BHT_STATS_EN
  logic [31:0] BrCount;
  logic [31:0] MissCount;
`endif

  modport master (
    output PCF, StallD, FlushD, StallE, FlushE, BranchE, BrTakenE, BranchTargetE,
`ifdef BHT_STATS_EN
    input  BrCount, MissCount,
`endif
    input  BHThit, PrePC, PredictMiss, Expc
  );

  modport slave (
    input  PCF, StallD, FlushD, StallE, FlushE, BranchE, BrTakenE, BranchTargetE,
`ifdef BHT_STATS_EN
    output BrCount, MissCount,
`endif
    output BHThit, PrePC, PredictMiss, Expc
  );
endinterface

// File: rtl/bht_predictor.sv
// rtl/bht_predictor.sv - direct-mapped branch history table with target buffer
// Optional BHT_STATS_EN adds wrapping branch and mispredict counters.
module bht_predictor #(
  parameter int         IDX_W    = 6,
  parameter logic [1:0] CNT_INIT = 2'b01
) (
  input  logic          clk,
  input  logic          rst,
  bht_predictor_if.slave bus
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;
  localparam logic [1:0] CNT_ALLOC = 2'(CNT_INIT + 2'b01);

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [1:0]         cnt_q    [ENTRIES];

  logic [31:0] pc_d, pc_e;
  logic        pred_d, pred_e;

  logic [IDX_W-1:0] idx_f, idx_e;
  logic [TAG_W-1:0] tag_f, tag_e;
  logic             bht_hit;

  assign idx_f = bus.PCF[IDX_W+1:2];
  assign tag_f = bus.PCF[31:IDX_W+2];
  assign idx_e = pc_e[IDX_W+1:2];
  assign tag_e = pc_e[31:IDX_W+2];

  // Lookup reads the array before any same-cycle write lands.
  assign bht_hit     = valid_q[idx_f] & (tag_q[idx_f] == tag_f) & cnt_q[idx_f][1];
  assign bus.BHThit  = bht_hit;
  assign bus.PrePC   = target_q[idx_f];
  assign bus.Expc    = pc_e;

  always_comb begin
    bus.PredictMiss = 2'b00;
    if (bus.BranchE && bus.BrTakenE && !pred_e)
      bus.PredictMiss = 2'b10;
    else if (bus.BranchE && !bus.BrTakenE && pred_e)
      bus.PredictMiss = 2'b01;
  end

  logic       upd_en;
  logic       upd_hit;
  logic       upd_wr;
  logic [1:0] cnt_cur;
  logic [1:0] cnt_nxt;

  always_comb begin
    upd_en  = bus.BranchE & ~bus.StallE;
    upd_hit = valid_q[idx_e] & (tag_q[idx_e] == tag_e);
    upd_wr  = upd_en & (upd_hit | bus.BrTakenE);
    cnt_cur = cnt_q[idx_e];
    cnt_nxt = CNT_ALLOC;
    if (upd_hit) begin
      if (bus.BrTakenE)
        cnt_nxt = (cnt_cur == 2'b11) ? 2'b11 : cnt_cur + 2'b01;
      else
        cnt_nxt = (cnt_cur == 2'b00) ? 2'b00 : cnt_cur - 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_INIT;
      end
    end else if (upd_wr) begin
      valid_q[idx_e]  <= 1'b1;
      tag_q[idx_e]    <= tag_e;
      target_q[idx_e] <= bus.BranchTargetE;
      cnt_q[idx_e]    <= cnt_nxt;
    end
  end

  // Prediction shadow pipeline; flush wins over stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_d   <= '0;
      pred_d <= 1'b0;
    end else if (bus.FlushD) begin
      pc_d   <= '0;
      pred_d <= 1'b0;
    end else if (!bus.StallD) begin
      pc_d   <= bus.PCF;
      pred_d <= bht_hit;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_e   <= '0;
      pred_e <= 1'b0;
    end else if (bus.FlushE) begin
      pc_e   <= '0;
      pred_e <= 1'b0;
    end else if (!bus.StallE) begin
      pc_e   <= pc_d;
      pred_e <= pred_d;
    end
  end

`ifdef BHT_STATS_EN
  logic [31:0] br_count_q, miss_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q   <= '0;
      miss_count_q <= '0;
    end else if (upd_en) begin
      br_count_q <= br_count_q + 32'd1;
      if (bus.PredictMiss != 2'b00)
        miss_count_q <= miss_count_q + 32'd1;
    end
  end

  assign bus.BrCount   = br_count_q;
  assign bus.MissCount = miss_count_q;
`endif
endmodule

// File: tb/tb_bht_predictor.sv
// tb/tb_bht_predictor.sv - directed and random checks of bht_predictor against a reference table
module tb_bht_predictor;
  localparam int IDX_W = 6;
  localparam int NENT  = 1 << IDX_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bht_predictor_if bus ();

  bht_predictor #(.IDX_W(IDX_W), .CNT_INIT(2'b01)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_assert = 0;
  int n_fail   = 0;

  bit          m_valid [NENT];
  logic [31:0] m_tag   [NENT];
  logic [31:0] m_tgt   [NENT];
  int          m_cnt   [NENT];
  logic [31:0] m_pd_pc, m_pe_pc;
  bit          m_pd_pred, m_pe_pred;
  logic [31:0] m_brc, m_msc;

  function automatic int midx(input logic [31:0] pc);
    return int'((pc >> 2) % NENT);
  endfunction

  function automatic logic [31:0] mtag(input logic [31:0] pc);
    return pc >> (IDX_W + 2);
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    int i;
    i = midx(pc);
    return m_valid[i] && (m_tag[i] == mtag(pc)) && (m_cnt[i] >= 2);
  endfunction

  function automatic logic [1:0] m_pm();
    if (bus.BranchE && bus.BrTakenE && !m_pe_pred) return 2'b10;
    if (bus.BranchE && !bus.BrTakenE && m_pe_pred) return 2'b01;
    return 2'b00;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NENT; i++) begin
      m_valid[i] = 1'b0;
      m_tag[i]   = '0;
      m_tgt[i]   = '0;
      m_cnt[i]   = 1;
    end
    m_pd_pc = '0; m_pd_pred = 1'b0;
    m_pe_pc = '0; m_pe_pred = 1'b0;
    m_brc = '0; m_msc = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [31:0] pcf, input bit sd, input bit fd, input bit se,
                        input bit fe, input bit br, input bit tk, input logic [31:0] bt);
    bus.PCF = pcf; bus.StallD = sd; bus.FlushD = fd; bus.StallE = se; bus.FlushE = fe;
    bus.BranchE = br; bus.BrTakenE = tk; bus.BranchTargetE = bt;
  endtask

  task automatic half();
    #4;
    chk("hit", 32'(bus.BHThit), 32'(m_hit(bus.PCF)));
    chk("prepc", bus.PrePC, m_tgt[midx(bus.PCF)]);
    chk("pmiss", 32'(bus.PredictMiss), 32'(m_pm()));
    chk("expc", bus.Expc, m_pe_pc);
`ifdef BHT_STATS_EN
    chk("brcount", bus.BrCount, m_brc);
    chk("misscount", bus.MissCount, m_msc);
`endif
  endtask

  task automatic tick();
    bit          hit_f;
    logic [1:0]  pm;
    int          i;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      hit_f = m_hit(bus.PCF);
      pm    = m_pm();
      if (bus.BranchE && !bus.StallE) begin
        m_brc = m_brc + 1;
        if (pm != 2'b00) m_msc = m_msc + 1;
        i = midx(m_pe_pc);
        if (m_valid[i] && m_tag[i] == mtag(m_pe_pc)) begin
          m_cnt[i] = bus.BrTakenE ? ((m_cnt[i] < 3) ? m_cnt[i] + 1 : 3)
                                  : ((m_cnt[i] > 0) ? m_cnt[i] - 1 : 0);
          m_tgt[i] = bus.BranchTargetE;
        end else if (bus.BrTakenE) begin
          m_valid[i] = 1'b1;
          m_tag[i]   = mtag(m_pe_pc);
          m_tgt[i]   = bus.BranchTargetE;
          m_cnt[i]   = 2;
        end
      end
      if (bus.FlushE) begin
        m_pe_pc = '0; m_pe_pred = 1'b0;
      end else if (!bus.StallE) begin
        m_pe_pc = m_pd_pc; m_pe_pred = m_pd_pred;
      end
      if (bus.FlushD) begin
        m_pd_pc = '0; m_pd_pred = 1'b0;
      end else if (!bus.StallD) begin
        m_pd_pc = bus.PCF; m_pd_pred = hit_f;
      end
    end
    #1;
  endtask

  task automatic fetch_chk(input logic [31:0] pc, input bit exp_hit, input logic [31:0] exp_pc);
    set_in(pc, 0, 0, 0, 0, 0, 0, 0);
    half();
    chk("fetch_hit", 32'(bus.BHThit), 32'(exp_hit));
    if (exp_hit) chk("fetch_prepc", bus.PrePC, exp_pc);
    tick();
  endtask

  // Fetch pc, let it reach EX, resolve it; hazard flush follows a mispredict.
  task automatic br_seq(input logic [31:0] pc, input bit tk, input logic [31:0] tgt,
                        input logic [1:0] exp_pm);
    set_in(pc, 0, 0, 0, 0, 0, 0, 0);       half(); tick();
    set_in(pc + 4, 0, 0, 0, 0, 0, 0, 0);   half(); tick();
    set_in(pc + 8, 0, exp_pm != 0, 0, exp_pm != 0, 1, tk, tgt);
    half();
    chk("br_pmiss", 32'(bus.PredictMiss), 32'(exp_pm));
    chk("br_expc", bus.Expc, pc);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pool [4];
    logic [31:0] pc;
    pool[0] = 32'h100; pool[1] = 32'h200; pool[2] = 32'h300; pool[3] = 32'h104;

    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    @(posedge clk); @(posedge clk);
    model_reset();
    #1;
    rst = 1'b0;

    set_in(32'h100, 0, 0, 0, 0, 0, 0, 0);
    half();
    chk("rst_hit", 32'(bus.BHThit), 32'd0);
    chk("rst_prepc", bus.PrePC, 32'd0);
    chk("rst_pmiss", 32'(bus.PredictMiss), 32'd0);
    chk("rst_expc", bus.Expc, 32'd0);
    tick();

    set_in(32'h104, 0, 0, 0, 0, 0, 0, 0); half(); tick();
    // EX resolves 0x100 while IF looks up 0x100: lookup still sees the empty entry.
    set_in(32'h100, 0, 1, 0, 1, 1, 1, 32'h80);
    half();
    chk("alloc_pmiss", 32'(bus.PredictMiss), 32'd2);
    chk("alloc_expc", bus.Expc, 32'h100);
    chk("same_idx_old", 32'(bus.BHThit), 32'd0);
    tick();
    set_in(32'h100, 0, 0, 0, 0, 0, 0, 0);
    half();
    chk("same_idx_new", 32'(bus.BHThit), 32'd1);
    chk("alloc_prepc", bus.PrePC, 32'h80);
    chk("flush_pmiss", 32'(bus.PredictMiss), 32'd0);
    chk("flush_expc", bus.Expc, 32'd0);
    tick();

    br_seq(32'h100, 1, 32'h80, 2'b00);
    br_seq(32'h100, 0, 32'h80, 2'b01);
    fetch_chk(32'h100, 1, 32'h80);
    br_seq(32'h100, 0, 32'h80, 2'b01);
    fetch_chk(32'h100, 0, 32'h0);

    br_seq(32'h100, 1, 32'h80, 2'b10);
    fetch_chk(32'h200, 0, 32'h0);
    fetch_chk(32'h100, 1, 32'h80);
    br_seq(32'h200, 1, 32'h40, 2'b10);
    fetch_chk(32'h100, 0, 32'h0);
    fetch_chk(32'h200, 1, 32'h40);

    set_in(32'h300, 0, 0, 0, 0, 0, 0, 0); half(); tick();
    set_in(32'h304, 0, 0, 0, 0, 0, 0, 0); half(); tick();
    for (int k = 0; k < 3; k++) begin
      set_in(32'h308, 1, 0, 1, 0, 1, 1, 32'h10);
      half();
      chk("stall_pmiss", 32'(bus.PredictMiss), 32'd2);
      chk("stall_expc", bus.Expc, 32'h300);
      tick();
    end
    set_in(32'h308, 0, 1, 0, 1, 1, 1, 32'h10);
    half();
    chk("release_pmiss", 32'(bus.PredictMiss), 32'd2);
    tick();
    set_in(32'h30c, 0, 0, 0, 0, 0, 0, 0);
    half();
    chk("flushe_pmiss", 32'(bus.PredictMiss), 32'd0);
    chk("flushe_expc", bus.Expc, 32'd0);
    tick();
    fetch_chk(32'h300, 1, 32'h10);
    br_seq(32'h300, 0, 32'h10, 2'b01);
    fetch_chk(32'h300, 0, 32'h0);

    rst = 1'b1;
    set_in(32'h200, 0, 0, 0, 0, 0, 0, 0); half(); tick();
    rst = 1'b0;
    set_in(32'h200, 0, 0, 0, 0, 0, 0, 0);
    half();
    chk("midrst_hit", 32'(bus.BHThit), 32'd0);
    chk("midrst_prepc", bus.PrePC, 32'd0);
    chk("midrst_expc", bus.Expc, 32'd0);
    tick();

    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 5))
        0, 1, 2: pc = pool[$urandom_range(0, 3)];
        3:       pc = 32'h1000 + ($urandom_range(0, 15) << 2);
        default: pc = $urandom;
      endcase
      rst = ($urandom_range(0, 199) == 0);
      set_in(pc, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             {$urandom_range(0, 255), 2'b00});
      half();
      tick();
    end
    rst = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
